// File: rtl/spike_pkg.sv
//------------------------------------------------------------------------------
// Module   : spike_pkg
// Purpose  : Shared types and constants for the spike bus (dispatcher and accumulators).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spike_pkg;

  localparam int c_ADDR_W      = 12;
  localparam int c_MAX_NEURONS = 64;
  localparam int c_IDX_W       = 6;
  localparam int c_CNT_W       = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dispatch_state_t;

  function automatic logic [c_CNT_W-1:0] popcount(input logic [c_MAX_NEURONS-1:0] v);
    logic [c_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < c_MAX_NEURONS; i++) begin
      n = n + {{(c_CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_prio_enc.sv
//------------------------------------------------------------------------------
// Module   : spike_prio_enc
// Purpose  : Combinational lowest-set-bit encoder returning index and found flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spike_prio_enc #(
  parameter int WIDTH = 10,
  parameter int IDX_W = 6
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_dispatcher.sv
//------------------------------------------------------------------------------
// Module   : spike_dispatcher
// Purpose  : Serialises a captured neuron-cluster fire vector onto the spike bus,
//            lowest index first, with one shadow timestep buffer.
//            Optional SPIKE_DISPATCH_COUNT_EN adds the spike_count output.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spike_dispatcher
  import spike_pkg::*;
#(
  parameter int                NUM_NEURONS = 10,
  parameter int                ADDR_W      = c_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   capture,
  output logic [ADDR_W-1:0]      src_addr,
  output logic                   src_valid,
  input  logic                   src_ready,
  output logic                   ts_done,
  output logic                   busy,
  output logic                   overrun
`ifdef SPIKE_DISPATCH_COUNT_EN
  ,output logic [c_CNT_W-1:0]    spike_count
`endif
);

  localparam logic [NUM_NEURONS-1:0] c_ONE = NUM_NEURONS'(1);

  dispatch_state_t        r_state;
  logic [NUM_NEURONS-1:0] r_pending;
  logic [NUM_NEURONS-1:0] r_shadow;
  logic                   r_shadow_valid;
  logic [ADDR_W-1:0]      r_src_addr;
  logic                   r_src_valid;
  logic                   r_ts_done;
  logic                   r_overrun;

  logic [NUM_NEURONS-1:0] w_load_src;
  logic                   w_load_en;
  logic [NUM_NEURONS-1:0] w_enc_in;
  logic [NUM_NEURONS-1:0] w_enc_rest;
  logic [c_IDX_W-1:0]     w_idx;
  logic                   w_found;
  logic [ADDR_W-1:0]      w_next_addr;
  logic                   w_beat;

  // One encoder serves both the IDLE load and the SEND advance.
  always_comb begin
    w_load_src = r_shadow_valid ? r_shadow : spike_in;
    w_load_en  = (r_state == IDLE) && (r_shadow_valid || capture);
    w_enc_in   = (r_state == IDLE) ? w_load_src : r_pending;
  end

  assign w_enc_rest  = w_enc_in & (w_enc_in - c_ONE);
  assign w_next_addr = BASE_ADDR + ADDR_W'(w_idx);
  assign w_beat      = r_src_valid && src_ready;

  spike_prio_enc #(
    .WIDTH (NUM_NEURONS),
    .IDX_W (c_IDX_W)
  ) u_prio_enc (
    .vec   (w_enc_in),
    .idx   (w_idx),
    .found (w_found)
  );

`ifdef SPIKE_DISPATCH_COUNT_EN
  logic [c_CNT_W-1:0]       r_spike_count;
  logic [c_MAX_NEURONS-1:0] w_pop_in;

  always_comb begin
    w_pop_in                  = '0;
    w_pop_in[NUM_NEURONS-1:0] = w_load_src;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_spike_count <= '0;
    end else if (w_load_en) begin
      r_spike_count <= popcount(w_pop_in);
    end
  end

  assign spike_count = r_spike_count;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= IDLE;
      r_pending      <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_src_addr     <= '0;
      r_src_valid    <= 1'b0;
      r_ts_done      <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_ts_done <= 1'b0;
      r_overrun <= 1'b0;

      if ((r_state != IDLE) && capture) begin
        if (!r_shadow_valid) begin
          r_shadow       <= spike_in;
          r_shadow_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_load_en) begin
            // Draining the shadow frees it for a capture arriving this same cycle.
            if (r_shadow_valid) begin
              r_shadow_valid <= capture;
              if (capture) begin
                r_shadow <= spike_in;
              end
            end
            if (w_found) begin
              r_src_addr  <= w_next_addr;
              r_pending   <= w_enc_rest;
              r_src_valid <= 1'b1;
              r_state     <= SEND;
            end else begin
              r_ts_done <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        SEND: begin
          if (w_beat) begin
            if (w_found) begin
              r_src_addr <= w_next_addr;
              r_pending  <= w_enc_rest;
            end else begin
              r_src_valid <= 1'b0;
              r_ts_done   <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign src_addr  = r_src_addr;
  assign src_valid = r_src_valid;
  assign ts_done   = r_ts_done;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
